// File: rtl/lsu_stage_pkg.sv
// Shared types and constants for the load/store stage: op codes, FSM state
// codes and the reset polarity.
package lsu_stage_pkg;

   localparam int unsigned LSU_OP_W    = 4;
   localparam int unsigned LSU_STATE_W = 2;
   localparam int unsigned STRB_W      = 4;
   localparam logic        RST_ENABLE  = 1'b0;

   typedef enum logic [LSU_OP_W-1:0] {
      LSU_OP_NONE = 4'd0,
      LSU_OP_LB   = 4'd1,
      LSU_OP_LH   = 4'd2,
      LSU_OP_LW   = 4'd3,
      LSU_OP_LBU  = 4'd4,
      LSU_OP_LHU  = 4'd5,
      LSU_OP_SB   = 4'd6,
      LSU_OP_SH   = 4'd7,
      LSU_OP_SW   = 4'd8
   } lsu_op_e;

   localparam logic [LSU_STATE_W-1:0] LSU_ST_IDLE = 2'd0;
   localparam logic [LSU_STATE_W-1:0] LSU_ST_REQ  = 2'd1;
   localparam logic [LSU_STATE_W-1:0] LSU_ST_WAIT = 2'd2;
   localparam logic [LSU_STATE_W-1:0] LSU_ST_DONE = 2'd3;

endpackage

// File: rtl/lsu_stage_if.sv
// Data-memory request/response port of the load/store stage.
interface lsu_stage_if
   import lsu_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_req_addr;
   logic              mem_req_wen;
   logic [DATA_W-1:0] mem_req_wdata;
   logic [STRB_W-1:0] mem_req_wstrb;
   logic              mem_rsp_valid;
   logic [DATA_W-1:0] mem_rsp_rdata;

   modport master (
      output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
   );
endinterface

// File: rtl/lsu_stage_align.sv
// Combinational lane logic: store byte replication/strobes, load extract and
// extend, and the alignment check for a given op and byte offset.
module lsu_align
   import lsu_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [LSU_OP_W-1:0] op_i,
   input  logic [1:0]          off_i,
   input  logic [DATA_W-1:0]   store_data_i,
   input  logic [DATA_W-1:0]   rdata_i,
   output logic [DATA_W-1:0]   wdata_o,
   output logic [STRB_W-1:0]   wstrb_o,
   output logic [DATA_W-1:0]   load_data_o,
   output logic                misalign_o,
   output logic                is_mem_o,
   output logic                is_store_o
);
   lsu_op_e           op;
   logic [DATA_W-1:0] shifted;

   always_comb begin
      op          = lsu_op_e'(op_i);
      shifted     = rdata_i >> {off_i, 3'b000};
      wdata_o     = '0;
      wstrb_o     = '0;
      load_data_o = '0;
      misalign_o  = 1'b0;
      is_mem_o    = 1'b1;
      is_store_o  = 1'b0;
      case (op)
         LSU_OP_LB:  load_data_o = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
         LSU_OP_LBU: load_data_o = {{(DATA_W-8){1'b0}}, shifted[7:0]};
         LSU_OP_LH: begin
            misalign_o  = off_i[0];
            load_data_o = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
         end
         LSU_OP_LHU: begin
            misalign_o  = off_i[0];
            load_data_o = {{(DATA_W-16){1'b0}}, shifted[15:0]};
         end
         LSU_OP_LW: begin
            misalign_o  = |off_i;
            load_data_o = shifted;
         end
         LSU_OP_SB: begin
            is_store_o = 1'b1;
            wdata_o    = {(DATA_W/8){store_data_i[7:0]}};
            wstrb_o    = 4'b0001 << off_i;
         end
         LSU_OP_SH: begin
            is_store_o = 1'b1;
            misalign_o = off_i[0];
            wdata_o    = {(DATA_W/16){store_data_i[15:0]}};
            wstrb_o    = 4'b0011 << off_i;
         end
         LSU_OP_SW: begin
            is_store_o = 1'b1;
            misalign_o = |off_i;
            wdata_o    = store_data_i;
            wstrb_o    = '1;
         end
         default: is_mem_o = 1'b0;
      endcase
   end
endmodule

// File: rtl/lsu_stage.sv
// Load/store stage: one instruction in flight, memory request/response
// transaction, aligned result handed to write-back on a valid/ready handshake.
module lsu_stage
   import lsu_stage_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LSU_OP_W-1:0] lsu_op_i,
   input  logic [ADDR_W-1:0]   alu_result_i,
   input  logic [DATA_W-1:0]   store_data_i,
   input  logic [4:0]          rd_addr_i,
   input  logic                rd_wen_i,
   lsu_stage_if.master         mem,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_W-1:0]   result_o,
   output logic [4:0]          rd_addr_o,
   output logic                rd_wen_o,
   output logic                misalign_o
);
   logic [LSU_STATE_W-1:0] state_q, state_d;
   logic [LSU_OP_W-1:0]    op_q, op_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [DATA_W-1:0]      sdata_q, sdata_d;
   logic [DATA_W-1:0]      result_q, result_d;
   logic [4:0]             rd_addr_q, rd_addr_d;
   logic                   rd_wen_q, rd_wen_d;
   logic                   misalign_q, misalign_d;

   logic                   idle, req_active;
   logic [LSU_OP_W-1:0]    al_op;
   logic [1:0]             al_off;
   logic [DATA_W-1:0]      al_wdata, al_load;
   logic [STRB_W-1:0]      al_wstrb;
   logic                   al_mis, al_mem, al_store;

   assign idle       = (state_q == LSU_ST_IDLE);
   assign req_active = (state_q == LSU_ST_REQ);

   // The aligner sees the live inputs while idle (for the capture-time
   // misalign decision) and the captured instruction afterwards.
   assign al_op  = idle ? lsu_op_i : op_q;
   assign al_off = idle ? alu_result_i[1:0] : addr_q[1:0];

   lsu_align #(.DATA_W(DATA_W)) u_align (
      .op_i         (al_op),
      .off_i        (al_off),
      .store_data_i (sdata_q),
      .rdata_i      (mem.mem_rsp_rdata),
      .wdata_o      (al_wdata),
      .wstrb_o      (al_wstrb),
      .load_data_o  (al_load),
      .misalign_o   (al_mis),
      .is_mem_o     (al_mem),
      .is_store_o   (al_store)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      sdata_d    = sdata_q;
      result_d   = result_q;
      rd_addr_d  = rd_addr_q;
      rd_wen_d   = rd_wen_q;
      misalign_d = misalign_q;
      case (state_q)
         LSU_ST_IDLE: begin
            if (in_valid) begin
               op_d       = lsu_op_i;
               addr_d     = alu_result_i;
               sdata_d    = store_data_i;
               rd_addr_d  = rd_addr_i;
               misalign_d = al_mis;
               rd_wen_d   = rd_wen_i & ~al_store & ~al_mis;
               result_d   = '0;
               if (!al_mem) begin
                  result_d = DATA_W'(alu_result_i);
                  state_d  = LSU_ST_DONE;
               end else if (al_mis) begin
                  state_d  = LSU_ST_DONE;
               end else begin
                  state_d  = LSU_ST_REQ;
               end
            end
         end
         LSU_ST_REQ: begin
            if (mem.mem_req_ready) begin
               if (mem.mem_rsp_valid) begin
                  result_d = al_store ? '0 : al_load;
                  state_d  = LSU_ST_DONE;
               end else begin
                  state_d  = LSU_ST_WAIT;
               end
            end
         end
         LSU_ST_WAIT: begin
            if (mem.mem_rsp_valid) begin
               result_d = al_store ? '0 : al_load;
               state_d  = LSU_ST_DONE;
            end
         end
         default: begin
            if (out_ready) state_d = LSU_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RST_ENABLE) begin
         state_q    <= LSU_ST_IDLE;
         op_q       <= '0;
         addr_q     <= '0;
         sdata_q    <= '0;
         result_q   <= '0;
         rd_addr_q  <= '0;
         rd_wen_q   <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         sdata_q    <= sdata_d;
         result_q   <= result_d;
         rd_addr_q  <= rd_addr_d;
         rd_wen_q   <= rd_wen_d;
         misalign_q <= misalign_d;
      end
   end

   assign in_ready           = idle;
   assign out_valid          = (state_q == LSU_ST_DONE);
   assign result_o           = result_q;
   assign rd_addr_o          = rd_addr_q;
   assign rd_wen_o           = rd_wen_q;
   assign misalign_o         = misalign_q;

   assign mem.mem_req_valid  = req_active;
   assign mem.mem_req_addr   = req_active ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem.mem_req_wen    = req_active & al_store;
   assign mem.mem_req_wdata  = req_active ? al_wdata : '0;
   assign mem.mem_req_wstrb  = req_active ? al_wstrb : '0;
endmodule

// File: tb/tb_lsu_stage.sv
// Directed and randomized checks of lsu_stage against a byte-arithmetic
// reference model.
module tb_lsu_stage;
   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  lsu_op_i;
   logic [31:0] alu_result_i;
   logic [31:0] store_data_i;
   logic [4:0]  rd_addr_i;
   logic        rd_wen_i;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;
   logic        rd_wen_o;
   logic        misalign_o;

   int checks   = 0;
   int failures = 0;

   lsu_stage_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

   lsu_stage #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .lsu_op_i     (lsu_op_i),
      .alu_result_i (alu_result_i),
      .store_data_i (store_data_i),
      .rd_addr_i    (rd_addr_i),
      .rd_wen_i     (rd_wen_i),
      .mem          (mem_if.master),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result_o     (result_o),
      .rd_addr_o    (rd_addr_o),
      .rd_wen_o     (rd_wen_o),
      .misalign_o   (misalign_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          mem;
      bit          store;
      bit          mis;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] result;
      bit          rd_wen;
   } exp_t;

   // Reference: access size from the op, misalignment as addr mod size,
   // load value as a masked, optionally sign-extended byte window.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] addr,
                                  input logic [31:0] sdata, input logic [31:0] rdata,
                                  input bit wen);
      exp_t            e;
      int unsigned     size = 0;
      int unsigned     off;
      bit              is_load = 0;
      bit              sgn = 0;
      longint unsigned v, mask;
      off = addr % 4;
      case (op)
         4'd1: begin size = 1; is_load = 1; sgn = 1; end
         4'd2: begin size = 2; is_load = 1; sgn = 1; end
         4'd3: begin size = 4; is_load = 1; end
         4'd4: begin size = 1; is_load = 1; end
         4'd5: begin size = 2; is_load = 1; end
         4'd6: size = 1;
         4'd7: size = 2;
         4'd8: size = 4;
         default: size = 0;
      endcase
      e.mem   = (size != 0);
      e.store = e.mem && !is_load;
      e.mis   = e.mem && ((addr % size) != 0);
      e.addr  = addr - off;
      e.wstrb = e.store ? 4'(((1 << size) - 1) << off) : 4'h0;
      if (size == 1)      e.wdata = (sdata & 32'hFF) * 32'h0101_0101;
      else if (size == 2) e.wdata = (sdata & 32'hFFFF) * 32'h0001_0001;
      else                e.wdata = sdata;
      mask = (64'd1 << (8 * size)) - 1;
      v    = (64'(rdata) >> (8 * off)) & mask;
      if (sgn && v >= (64'd1 << (8 * size - 1))) v = v | ~mask;
      if (!e.mem)                e.result = addr;
      else if (e.mis || e.store) e.result = 32'h0;
      else                       e.result = v[31:0];
      e.rd_wen = wen && !e.store && !e.mis;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"},  in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_req_valid"}, mem_if.mem_req_valid, 0);
      chk({tag, "_req_addr"},  mem_if.mem_req_addr, 0);
      chk({tag, "_req_wen"},   mem_if.mem_req_wen, 0);
      chk({tag, "_req_wstrb"}, mem_if.mem_req_wstrb, 0);
      chk({tag, "_req_wdata"}, mem_if.mem_req_wdata, 0);
      chk({tag, "_result"},    result_o, 0);
      chk({tag, "_rd_addr"},   rd_addr_o, 0);
      chk({tag, "_rd_wen"},    rd_wen_o, 0);
      chk({tag, "_misalign"},  misalign_o, 0);
   endtask

   task automatic do_txn(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input bit wen,
                         input int unsigned req_stall, input int unsigned rsp_delay,
                         input int unsigned out_stall);
      exp_t e;
      e = model(op, addr, sdata, rdata, wen);
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_out_valid", out_valid, 0);
      in_valid = 1; lsu_op_i = op; alu_result_i = addr; store_data_i = sdata;
      rd_addr_i = rd; rd_wen_i = wen;
      @(negedge clk);
      in_valid = 0; lsu_op_i = 4'($urandom); alu_result_i = $urandom;
      store_data_i = $urandom; rd_addr_i = 5'($urandom); rd_wen_i = 1'($urandom);
      if (e.mem && !e.mis) begin
         for (int unsigned c = 0; c <= req_stall; c++) begin
            chk("req_valid", mem_if.mem_req_valid, 1);
            chk("req_addr", mem_if.mem_req_addr, e.addr);
            chk("req_wen", mem_if.mem_req_wen, e.store);
            chk("req_wstrb", mem_if.mem_req_wstrb, e.wstrb);
            if (e.store) chk("req_wdata", mem_if.mem_req_wdata, e.wdata);
            chk("req_in_ready", in_ready, 0);
            chk("req_out_valid", out_valid, 0);
            if (c < req_stall) begin
               mem_if.mem_req_ready = 0;
               mem_if.mem_rsp_valid = 1;
               mem_if.mem_rsp_rdata = $urandom;
               @(negedge clk);
            end
         end
         mem_if.mem_req_ready = 1;
         mem_if.mem_rsp_valid = (rsp_delay == 0);
         mem_if.mem_rsp_rdata = rdata;
         @(negedge clk);
         mem_if.mem_req_ready = 0;
         mem_if.mem_rsp_valid = 0;
         for (int unsigned c = 0; c < rsp_delay; c++) begin
            chk("wait_out_valid", out_valid, 0);
            chk("wait_req_valid", mem_if.mem_req_valid, 0);
            chk("wait_in_ready", in_ready, 0);
            if (c == rsp_delay - 1) begin
               mem_if.mem_rsp_valid = 1;
               mem_if.mem_rsp_rdata = rdata;
            end
            @(negedge clk);
            mem_if.mem_rsp_valid = 0;
         end
      end else begin
         chk("no_req_valid", mem_if.mem_req_valid, 0);
      end
      for (int unsigned c = 0; c <= out_stall; c++) begin
         chk("done_out_valid", out_valid, 1);
         chk("done_result", result_o, e.result);
         chk("done_rd_addr", rd_addr_o, rd);
         chk("done_rd_wen", rd_wen_o, e.rd_wen);
         chk("done_misalign", misalign_o, e.mis);
         chk("done_in_ready", in_ready, 0);
         chk("done_req_valid", mem_if.mem_req_valid, 0);
         if (c < out_stall) begin
            mem_if.mem_rsp_valid = 1;
            mem_if.mem_rsp_rdata = ~rdata;
            @(negedge clk);
            mem_if.mem_rsp_valid = 0;
         end
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("after_out_valid", out_valid, 0);
      chk("after_in_ready", in_ready, 1);
   endtask

   initial begin
      rst = 0; in_valid = 0; out_ready = 0; lsu_op_i = 0; alu_result_i = 0;
      store_data_i = 0; rd_addr_i = 0; rd_wen_i = 0;
      mem_if.mem_req_ready = 0; mem_if.mem_rsp_valid = 0; mem_if.mem_rsp_rdata = 0;
      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      rst = 1;

      do_txn(4'd0, 32'h1234_5678, 32'h0, 32'h0, 5'd3, 1, 0, 0, 0);
      do_txn(4'd6, 32'h8000_0003, 32'h0000_00AB, 32'hDEAD_BEEF, 5'd4, 1, 0, 0, 0);
      do_txn(4'd2, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 5'd5, 1, 0, 1, 0);
      do_txn(4'd5, 32'h8000_0002, 32'h0, 32'h8001_7FFF, 5'd6, 1, 0, 0, 0);
      do_txn(4'd3, 32'h8000_0006, 32'h0, 32'h1111_1111, 5'd7, 1, 0, 0, 0);
      do_txn(4'd3, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 5'd8, 1, 3, 2, 2);
      do_txn(4'd7, 32'hFFFF_FFFE, 32'h1234_BEEF, 32'h0, 5'd9, 1, 1, 0, 1);

      // Reset while a request is pending: the request drops without a clock edge.
      @(negedge clk);
      in_valid = 1; lsu_op_i = 4'd3; alu_result_i = 32'h40; rd_addr_i = 5'd1; rd_wen_i = 1;
      @(negedge clk);
      in_valid = 0;
      chk("pre_rst_req_valid", mem_if.mem_req_valid, 1);
      #2 rst = 0;
      #1 chk_all_zero("rst_in_req");
      @(negedge clk); rst = 1;

      // Reset while waiting for the response.
      in_valid = 1; lsu_op_i = 4'd3; alu_result_i = 32'h80; rd_addr_i = 5'd2; rd_wen_i = 1;
      @(negedge clk);
      in_valid = 0; mem_if.mem_req_ready = 1;
      @(negedge clk);
      mem_if.mem_req_ready = 0;
      chk("wait_before_rst", mem_if.mem_req_valid, 0);
      #2 rst = 0;
      #1 chk_all_zero("rst_in_wait");
      @(negedge clk); rst = 1;
      do_txn(4'd4, 32'h0000_0101, 32'h0, 32'h1234_9A78, 5'd10, 1, 0, 1, 0);

      for (int n = 0; n < 40; n++) begin
         do_txn(4'($urandom_range(0, 8)), $urandom, $urandom, $urandom,
                5'($urandom), 1'($urandom), $urandom_range(0, 2),
                $urandom_range(0, 2), $urandom_range(0, 2));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
